mod997_residue_acc: RTL and testbench

MOD997_RESIDUE_ACC -- requirements
Module: mod997_residue_acc

---
 rtl/mod997_pkg.sv | 14 +
 rtl/mod997_add.sv | 21 ++
 rtl/mod997_residue_acc.sv | 113 +++++++++++
 tb/tb_mod997_residue_acc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mod997_pkg.sv
// Shared parameters and FSM state encoding for the mod-997 residue accumulator.
package mod997_pkg;

  localparam int MOD    = 997;
  localparam int W      = 10;
  localparam int CHUNKS = 50;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mod997_add.sv
// Combinational modular add: pre-reduce the incoming partial residue, add it to base, fold once.
module mod997_add #(
  parameter int MOD = 997,
  parameter int W   = 10
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum
);

  logic [W-1:0] data_red;
  logic [W:0]   raw;

  // LUT outputs may exceed MOD by up to 2^W-1-MOD, so one subtract brings them into range.
  always_comb begin
    data_red = (data >= W'(MOD)) ? data - W'(MOD) : data;
    raw      = {1'b0, base} + {1'b0, data_red};
    sum      = (raw >= (W+1)'(MOD)) ? W'(raw - (W+1)'(MOD)) : raw[W-1:0];
  end

endmodule

// File: rtl/mod997_residue_acc.sv
// Frame residue accumulator: folds per-chunk partial residues into one value modulo MOD.
// Optional chunk-count checking (out_err) is enabled by defining MOD997_ACC_CNTCHK_EN.
module mod997_residue_acc #(
  parameter int MOD    = mod997_pkg::MOD,
  parameter int W      = mod997_pkg::W,
  parameter int CHUNKS = mod997_pkg::CHUNKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_first,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   dbg_state
`ifdef MOD997_ACC_CNTCHK_EN
  ,
  output logic         out_err
`endif
);

  import mod997_pkg::*;

  // Handshakes: a beat transfers on a rising edge where valid && ready; a valid
  // source holds its data stable until that edge, and ready never depends on valid.

  state_t       state;
  logic [W-1:0] acc;
  logic [W-1:0] base;
  logic [W-1:0] sum;
  logic         beat;

  assign beat      = in_valid && in_ready;
  assign in_ready  = (state != OUT);
  assign out_valid = (state == OUT);
  assign out_data  = acc;
  assign dbg_state = state;

  // A first beat always restarts from zero, both from IDLE and mid-frame.
  assign base = (in_first || state == IDLE) ? '0 : acc;

  mod997_add #(.MOD(MOD), .W(W)) u_add (
    .base (base),
    .data (in_data),
    .sum  (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (beat && in_first) begin
            acc   <= sum;
            state <= in_last ? OUT : ACC;
          end
        end
        ACC: begin
          if (beat) begin
            acc <= sum;
            if (in_last) state <= OUT;
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MOD997_ACC_CNTCHK_EN
  localparam int CW = $clog2(CHUNKS + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          restart;
  logic          restart_next;

  always_comb begin
    cnt_next     = in_first ? CW'(1) : ((cnt == CW'(CHUNKS)) ? cnt : cnt + CW'(1));
    restart_next = (state == ACC) && (restart || in_first);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      restart <= 1'b0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (beat && (in_first || state == ACC)) begin
            cnt     <= cnt_next;
            restart <= restart_next;
            if (in_last) out_err <= (cnt_next != CW'(CHUNKS)) || restart_next;
          end
        end
        OUT: begin
          if (out_ready) out_err <= 1'b0;
        end
        default: out_err <= 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_mod997_residue_acc.sv
// Directed bench for mod997_residue_acc: vector table of short frames plus hand-written corner sequences.
module tb_mod997_residue_acc;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   dbg_state;
`ifdef MOD997_ACC_CNTCHK_EN
  logic         out_err;
`endif

  int checks = 0;
  int errors = 0;

  mod997_residue_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .dbg_state (dbg_state)
`ifdef MOD997_ACC_CNTCHK_EN
    ,
    .out_err   (out_err)
`endif
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct {
    int           n;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Driver: present one beat and hold it until accepted (bounded), returning #1 after the edge.
  task automatic send(input logic [W-1:0] d, input logic first, input logic last);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_first = first;
    in_last  = last;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{n: 1, d0: 10'd5,    d1: 10'd0,    exp: 10'd5};
    vecs[1] = '{n: 2, d0: 10'd996,  d1: 10'd996,  exp: 10'd995};
    vecs[2] = '{n: 1, d0: 10'd1000, d1: 10'd0,    exp: 10'd3};
    vecs[3] = '{n: 1, d0: 10'd1023, d1: 10'd0,    exp: 10'd26};
    vecs[4] = '{n: 2, d0: 10'd1023, d1: 10'd1023, exp: 10'd52};
    vecs[5] = '{n: 2, d0: 10'd500,  d1: 10'd497,  exp: 10'd0};
    vecs[6] = '{n: 2, d0: 10'd0,    d1: 10'd0,    exp: 10'd0};
    vecs[7] = '{n: 1, d0: 10'd996,  d1: 10'd0,    exp: 10'd996};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_state", 32'(dbg_state), 32'd0);
`ifdef MOD997_ACC_CNTCHK_EN
    check("reset_out_err", 32'(out_err), 32'd0);
`endif

    // Table of short frames: out_valid must rise the cycle after the last beat.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d0, 1'b1, vecs[i].n == 1);
      if (vecs[i].n == 2) begin
        check($sformatf("vec%0d_mid_out_valid", i), 32'(out_valid), 32'd0);
        send(vecs[i].d1, 1'b0, 1'b1);
      end
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp));
      drain();
    end

    // Backpressure: result held, upstream stalled, pending beat taken only after IDLE returns.
    send(10'd7, 1'b1, 1'b1);
    in_valid = 1'b1;
    in_data  = 10'd9;
    in_first = 1'b1;
    in_last  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_out_data", c), 32'(out_data), 32'd7);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("bp_hold_out_data", 32'(out_data), 32'd7);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_handshake_out_valid", 32'(out_valid), 32'd0);
    check("bp_handshake_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    check("bp_next_out_valid", 32'(out_valid), 32'd1);
    check("bp_next_out_data", 32'(out_data), 32'd9);
    drain();

    // A beat without in_first in IDLE is swallowed.
    send(10'd100, 1'b0, 1'b1);
    check("discard_out_valid", 32'(out_valid), 32'd0);
    check("discard_in_ready", 32'(in_ready), 32'd1);
    send(10'd4, 1'b1, 1'b1);
    check("after_discard_out_data", 32'(out_data), 32'd4);
    drain();

    // Full 50-beat frame: 50*20 = 1000 -> 3.
    for (int i = 0; i < 50; i++) send(10'd20, i == 0, i == 49);
    check("f50_out_valid", 32'(out_valid), 32'd1);
    check("f50_out_data", 32'(out_data), 32'd3);
`ifdef MOD997_ACC_CNTCHK_EN
    check("f50_out_err", 32'(out_err), 32'd0);
`endif
    drain();

    // Short 49-beat frame: 980.
    for (int i = 0; i < 49; i++) send(10'd20, i == 0, i == 48);
    check("f49_out_data", 32'(out_data), 32'd980);
`ifdef MOD997_ACC_CNTCHK_EN
    check("f49_out_err", 32'(out_err), 32'd1);
`endif
    drain();

    // Mid-frame restart: only 5 + 6 survive.
    send(10'd10, 1'b1, 1'b0);
    send(10'd20, 1'b0, 1'b0);
    send(10'd5, 1'b1, 1'b0);
    send(10'd6, 1'b0, 1'b1);
    check("restart_out_data", 32'(out_data), 32'd11);
`ifdef MOD997_ACC_CNTCHK_EN
    check("restart_out_err", 32'(out_err), 32'd1);
`endif
    drain();

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 10; i++) send(10'd7, i == 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_data", 32'(out_data), 32'd0);
    send(10'd1, 1'b1, 1'b0);
    send(10'd2, 1'b0, 1'b1);
    check("postrst_out_valid", 32'(out_valid), 32'd1);
    check("postrst_out_data", 32'(out_data), 32'd3);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
